// File: rtl/keyboard_pkg.sv
// Shared constants for the keyboard scancode queue.
package keyboard_pkg;

    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] ASCII_NONE = 8'h00;

    localparam int unsigned DEPTH_DEFAULT = 16;

    // Codes that are protocol framing rather than keys; never produce a character.
    function automatic logic sc_ignored(input logic [7:0] code);
        return (code == 8'h00) || (code == SC_EXT) || (code == SC_BREAK);
    endfunction

endpackage

// File: rtl/keycode_ascii.sv
// Set-2 scancode to ASCII translation table (letters, digits, space, enter, backspace).
module keycode_ascii
    import keyboard_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] letter;

    // Lower-case letter lookup; upper case is derived by offset.
    always_comb begin
        letter = ASCII_NONE;
        case (code)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            default: letter = ASCII_NONE;
        endcase
    end

    // Final character: letters, then digit row with shifted symbols, then control keys.
    always_comb begin
        ascii = ASCII_NONE;
        if (letter != ASCII_NONE) begin
            ascii = shift ? (letter - 8'h20) : letter;
        end else begin
            case (code)
                8'h16: ascii = shift ? "!" : "1";
                8'h1E: ascii = shift ? "@" : "2";
                8'h26: ascii = shift ? "#" : "3";
                8'h25: ascii = shift ? "$" : "4";
                8'h2E: ascii = shift ? "%" : "5";
                8'h36: ascii = shift ? "^" : "6";
                8'h3D: ascii = shift ? "&" : "7";
                8'h3E: ascii = shift ? "*" : "8";
                8'h46: ascii = shift ? "(" : "9";
                8'h45: ascii = shift ? ")" : "0";
                8'h29: ascii = 8'h20;
                8'h5A: ascii = 8'h0A;
                8'h66: ascii = 8'h08;
                default: ascii = ASCII_NONE;
            endcase
        end
    end

endmodule

// File: rtl/keyboard_queue.sv
// Detects keyboard make/break events, tracks Shift and queues ASCII in a fall-through FIFO.
module keyboard_queue
    import keyboard_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               keycode,
    input  logic [7:0]               key_status,
    input  logic                     rd_en,
    input  logic                     ovf_clr,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [8:0]       in_q, in_d;
    logic [8:0]       prev_q, prev_d;
    logic             lshift_q, lshift_d, rshift_q, rshift_d;
    logic             ev_valid_q, ev_valid_d;
    logic [7:0]       ev_ascii_q, ev_ascii_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       mem_q [DEPTH];

    logic [7:0] in_code;
    logic       in_brk;
    logic [7:0] map_ascii;
    logic       full, do_pop, do_push, drop;
    logic       unused_status;

    assign unused_status = ^key_status[7:1];
    assign in_code = in_q[7:0];
    assign in_brk  = in_q[8];
    assign in_d    = {key_status[0], keycode};

    keycode_ascii u_keycode_ascii (
        .code  (in_code),
        .shift (lshift_q | rshift_q),
        .ascii (map_ascii)
    );

    // Event detect, shift tracking and translation into the stage-2 registers.
    always_comb begin
        prev_d     = prev_q;
        lshift_d   = lshift_q;
        rshift_d   = rshift_q;
        ev_valid_d = 1'b0;
        ev_ascii_d = ASCII_NONE;
        if (in_q != prev_q) begin
            prev_d = in_q;
            if (!sc_ignored(in_code)) begin
                if (in_code == SC_LSHIFT) begin
                    lshift_d = !in_brk;
                end else if (in_code == SC_RSHIFT) begin
                    rshift_d = !in_brk;
                end else if (!in_brk && (map_ascii != ASCII_NONE)) begin
                    ev_valid_d = 1'b1;
                    ev_ascii_d = map_ascii;
                end
            end
        end
    end

    // FIFO control; a pop on an empty FIFO is ignored even when a write arrives.
    always_comb begin
        full       = (count_q == CNT_W'(DEPTH));
        do_pop     = rd_en && (count_q != '0);
        do_push    = ev_valid_q && (!full || do_pop);
        drop       = ev_valid_q && full && !do_pop;
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
    end

    // Pipeline, shift and FIFO control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q       <= 9'h000;
            prev_q     <= 9'h100;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_ascii_q <= ASCII_NONE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            in_q       <= in_d;
            prev_q     <= prev_d;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            ev_valid_q <= ev_valid_d;
            ev_ascii_q <= ev_ascii_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= ev_ascii_q;
        end
    end

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = empty ? ASCII_NONE : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_keyboard_queue.sv
// Directed self-checking bench for keyboard_queue.
module tb_keyboard_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic [7:0] key_status = 8'h00;
    logic       rd_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] LETTERS [17] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15
    };

    keyboard_queue #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .keycode    (keycode),
        .key_status (key_status),
        .rd_en      (rd_en),
        .ovf_clr    (ovf_clr),
        .rd_data    (rd_data),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; keycode = 8'h00; key_status = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] code, input logic brk);
        keycode = code;
        key_status = {7'h00, brk};
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_basic();
        do_reset();
        send(8'h1C, 1'b0);  // E1
        tick();             // E2
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_latency_e2 empty got=%b exp=1", empty); end
        tick();             // E3
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_latency_e3 empty got=%b exp=0", empty); end
        checks++; if (rd_data !== 8'h61) begin errors++; $display("FAIL basic_rd_data got=%h exp=61", rd_data); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", count); end
        send(8'h1C, 1'b1);
        repeat (4) tick();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL basic_break_count got=%0d exp=1", count); end
    endtask

    task automatic test_shift();
        do_reset();
        send(8'h12, 1'b0);
        send(8'h1C, 1'b0);
        send(8'h1C, 1'b1);
        send(8'h12, 1'b1);
        send(8'h16, 1'b0);
        repeat (4) tick();
        checks++; if (count !== 5'd2) begin errors++; $display("FAIL shift_count2 got=%0d exp=2", count); end
        checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL shift_head_A got=%h exp=41", rd_data); end
        pop();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL shift_count1 got=%0d exp=1", count); end
        checks++; if (rd_data !== 8'h31) begin errors++; $display("FAIL shift_head_1 got=%h exp=31", rd_data); end
        pop();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL shift_count0 got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL shift_empty got=%b exp=1", empty); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL shift_rd_empty got=%h exp=00", rd_data); end
    endtask

    task automatic test_hold();
        do_reset();
        send(8'h1C, 1'b0);
        repeat (100) tick();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL hold_count got=%0d exp=1", count); end
        checks++; if (rd_data !== 8'h61) begin errors++; $display("FAIL hold_rd_data got=%h exp=61", rd_data); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(LETTERS[i], 1'b0);
            send(LETTERS[i], 1'b1);
        end
        repeat (4) tick();
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rd_data !== 8'h61 + 8'(i)) begin
                errors++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, rd_data, 8'h61 + 8'(i));
            end
            pop();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained_empty got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(LETTERS[i], 1'b0);
            send(LETTERS[i], 1'b1);
        end
        repeat (4) tick();
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullrw_fill got=%0d exp=16", count); end
        send(8'h1A, 1'b0);  // E1
        tick();             // E2
        rd_en = 1'b1;
        tick();             // E3: pop and push together
        rd_en = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullrw_count got=%0d exp=16", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullrw_overflow got=%b exp=0", overflow); end
        checks++; if (rd_data !== 8'h62) begin errors++; $display("FAIL fullrw_head got=%h exp=62", rd_data); end
        for (int i = 1; i < 16; i++) begin
            if (rd_data !== 8'h61 + 8'(i)) begin
                errors++; $display("FAIL fullrw_data[%0d] got=%h exp=%h", i, rd_data, 8'h61 + 8'(i));
            end
            checks++;
            pop();
        end
        checks++; if (rd_data !== 8'h7A) begin errors++; $display("FAIL fullrw_tail got=%h exp=7a", rd_data); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL fullrw_tail_count got=%0d exp=1", count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [5];
        exp[0] = 8'h53; exp[1] = 8'h20; exp[2] = 8'h40; exp[3] = 8'h0A; exp[4] = 8'h08;
        do_reset();
        send(8'h59, 1'b0);
        send(8'h1B, 1'b0);  // lands one cycle after the shift make
        send(8'h29, 1'b0);
        send(8'h1E, 1'b0);
        send(8'h59, 1'b1);
        send(8'h5A, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);  // unmapped
        send(8'hF0, 1'b0);  // framing code
        repeat (4) tick();
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", count); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rd_data !== exp[i]) begin
                errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rd_data, exp[i]);
            end
            pop();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h1C, 1'b0);  // make now in in_q
        rst = 1'b1;
        keycode = 8'h00;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_rd_data got=%h exp=00", rd_data); end
        tick();
        rst = 1'b0;
        repeat (6) tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_later_empty got=%b exp=1", empty); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_later_count got=%0d exp=0", count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_hold();
        test_overflow();
        test_full_rw();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
